// File: rtl/pipelined_wallace_multiplier.sv
// rtl/pipelined_wallace_multiplier.sv - 3-stage Baugh-Wooley/Wallace multiplier with valid/ready flow control.
// Optional running accumulator on the output handshake is enabled by defining WTM_ACCUMULATE_EN.
module pipelined_wallace_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 p_signed
`ifdef WTM_ACCUMULATE_EN
   ,
   input  logic                 acc_en,
   input  logic                 acc_clr,
   output logic [2*WIDTH-1:0]   acc
`endif
);

   localparam int PW    = 2 * WIDTH;
   localparam int NROWS = WIDTH + 1;

   // Baugh-Wooley correction: ones at columns WIDTH and PW-1.
   localparam logic [PW-1:0] BW_CONST = {1'b1, {(PW-WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

   function automatic int csa_levels(input int rows);
      int n;
      int lv;
      n  = rows;
      lv = 0;
      while (n > 2) begin
         n  = 2 * (n / 3) + n % 3;
         lv = lv + 1;
      end
      return lv;
   endfunction

   localparam int NLEV = csa_levels(NROWS);

   logic          r_v1;
   logic          r_v2;
   logic          r_v3;
   logic [PW-1:0] r_s1_rows [WIDTH];
   logic          r_s1_signed;
   logic [PW-1:0] r_s2_sum;
   logic [PW-1:0] r_s2_carry;
   logic          r_s2_signed;
   logic [PW-1:0] r_p;
   logic          r_p_signed;

   logic          w_adv1;
   logic          w_adv2;
   logic          w_adv3;
   logic [PW-1:0] w_pp [WIDTH];
   logic [PW-1:0] w_sum;
   logic [PW-1:0] w_carry;

   // Each stage may load when empty or when its occupant leaves this cycle.
   assign w_adv3    = !r_v3 || out_ready;
   assign w_adv2    = !r_v2 || w_adv3;
   assign w_adv1    = !r_v1 || w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_v3;
   assign p         = r_p;
   assign p_signed  = r_p_signed;

   always_comb begin : p_partial
      for (int i = 0; i < WIDTH; i++) begin
         w_pp[i] = '0;
         for (int j = 0; j < WIDTH; j++) begin
            w_pp[i][i+j] = (a[j] & b[i]) ^ (is_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
         end
      end
   end

   // Carry-save tree: every level compresses groups of three rows into sum + shifted carry.
   always_comb begin : p_reduce
      logic [PW-1:0] t_cur [NROWS];
      logic [PW-1:0] t_nxt [NROWS];
      int            n;
      int            g;
      for (int r = 0; r < WIDTH; r++) begin
         t_cur[r] = r_s1_rows[r];
      end
      t_cur[WIDTH] = r_s1_signed ? BW_CONST : '0;
      n = NROWS;
      g = 0;
      for (int l = 0; l < NLEV; l++) begin
         g = n / 3;
         for (int r = 0; r < NROWS; r++) begin
            t_nxt[r] = '0;
         end
         for (int k = 0; k < NROWS / 3; k++) begin
            if (k < g) begin
               t_nxt[2*k]   = t_cur[3*k] ^ t_cur[3*k+1] ^ t_cur[3*k+2];
               t_nxt[2*k+1] = ((t_cur[3*k] & t_cur[3*k+1]) |
                               (t_cur[3*k] & t_cur[3*k+2]) |
                               (t_cur[3*k+1] & t_cur[3*k+2])) << 1;
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (r < n % 3) begin
               t_nxt[2*g+r] = t_cur[3*g+r];
            end
         end
         for (int r = 0; r < NROWS; r++) begin
            t_cur[r] = t_nxt[r];
         end
         n = 2 * g + n % 3;
      end
      w_sum   = t_cur[0];
      w_carry = t_cur[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_v3       <= 1'b0;
         r_p        <= '0;
         r_p_signed <= 1'b0;
      end else begin
         if (w_adv1) r_v1 <= in_valid;
         if (w_adv2) r_v2 <= r_v1;
         if (w_adv3) r_v3 <= r_v2;
         if (w_adv3 && r_v2) begin
            r_p        <= r_s2_sum + r_s2_carry;
            r_p_signed <= r_s2_signed;
         end
      end
   end

   // Datapath registers need no reset: their valid bits gate every use.
   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) begin
         r_s1_rows   <= w_pp;
         r_s1_signed <= is_signed;
      end
      if (w_adv2 && r_v1) begin
         r_s2_sum    <= w_sum;
         r_s2_carry  <= w_carry;
         r_s2_signed <= r_s1_signed;
      end
   end

`ifdef WTM_ACCUMULATE_EN
   logic          r_s1_acc_en;
   logic          r_s2_acc_en;
   logic          r_s3_acc_en;
   logic [PW-1:0] r_acc;
   logic          w_drain;

   assign w_drain = r_v3 && out_ready;
   assign acc     = r_acc;

   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) r_s1_acc_en <= acc_en;
      if (w_adv2 && r_v1)     r_s2_acc_en <= r_s1_acc_en;
      if (w_adv3 && r_v2)     r_s3_acc_en <= r_s2_acc_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_drain && r_s3_acc_en) begin
         r_acc <= (acc_clr ? '0 : r_acc) + r_p;
      end else if (acc_clr) begin
         r_acc <= '0;
      end
   end
`endif

endmodule

// File: doc/pipelined_wallace_multiplier.md
Name: pipelined_wallace_multiplier

Overview:
Parametrised, 3-stage pipelined Wallace-tree multiplier with a per-operand signed/unsigned mode. It replaces the 32x32 combinational multiplier in the datapath.
Valid/ready handshakes on both sides give full throughput (one product per clock) and lossless backpressure. Default width is 32 bits, giving a 64-bit product.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..64.
PW, 2*WIDTH, product width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  PW  product
p_signed  output  1  is_signed value carried alongside the product

Behaviour:
- Reset: asynchronous, active-low; affects all valid bits and all outputs.
  - On assertion: out_valid=0, p=0, p_signed=0, all stage valid bits=0, in_ready=1 once reset is released.
  - Data registers may also be cleared.
  - Reset mid-operation discards every in-flight product; no partial output appears after release.
- Stage S1 (accept), on in_valid && in_ready:
  - Register all WIDTH partial-product rows.
  - Signed mode uses Baugh-Wooley: invert the MSB terms and inject the constant 1s at columns WIDTH and PW-1.
  - Register is_signed with the rows.
- Stage S2: Wallace reduction of the S1 rows using full/half adders down to two PW-bit rows (sum, carry); registered.
- Stage S3: final PW-bit carry-propagate add of sum+carry, registered to p. Arithmetic is modulo 2^PW; the result is always exact, no overflow.
- Latency: 3 cycles from accepting handshake to out_valid, when not stalled.
- Throughput: one result per cycle while out_ready=1.
- Advance rule: stage k loads when stage k is empty or its contents move downstream this cycle.
  - S3 drains on out_valid && out_ready.
  - in_ready = !v1 || advance1, where advance1 = !v2 || advance2, and so on.
  - in_ready is combinational from out_ready through the chain; no combinational path from in_valid to in_ready.
- Backpressure:
  - While out_valid=1 and out_ready=0: p and p_signed hold stable.
  - Once all three stages are full, in_ready=0 and no operand is lost or duplicated.
- Simultaneous accept and drain in the same cycle with a full pipeline: all stages shift and in_ready stays 1.
- Bubbles: empty stages do not hold back upstream stages. Ordering is strictly FIFO.
- Data on a/b/is_signed is ignored when in_valid=0.

Optional Feature:
Macro: WTM_ACCUMULATE_EN.
- Defined:
  - Adds ports acc_en (input 1, sampled with a/b), acc_clr (input 1, synchronous), and acc (output PW).
  - When a product with acc_en=1 is accepted at the output handshake, acc <= acc + p, modulo 2^PW.
  - acc_clr=1 sets acc to 0 on the next edge; if it coincides with an accumulating handshake, acc <= p.
  - acc resets to 0 on rst_n.
- Not defined: none of these ports exist and the core behaves exactly as above.

Test Plan:
- Unsigned basic: a=0x80000280, b=0x60, is_signed=0 -> p=206158491648 exactly 3 cycles after accept.
- Signed corners:
  - a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=1 -> p=1.
  - Same operands with is_signed=0 -> p=0xFFFFFFFE00000001.
  - a=0x80000000, b=0x80000000, is_signed=1 -> p=0x4000000000000000.
- Throughput: 100 random back-to-back pairs with out_ready=1 -> 100 results in order on consecutive cycles, each matching a reference model.
- Backpressure: out_ready=0 for 10 cycles while feeding -> in_ready drops after 3 accepts, p held stable; release -> no loss or duplication.
- Reset mid-flight: pulse rst_n low with 2 products in flight -> out_valid=0 immediately (async), no stale product after release.
- WTM_ACCUMULATE_EN build: acc_clr, then 3 accumulating products 2*3, 4*5, -1*7 (signed) -> acc=19 (mod 2^64).
